// File: rtl/pb_debounce_repeat.sv
// Pushbutton front-end: two-flop synchroniser, saturating-counter debounce, one-cycle press/release pulses.
// Auto-repeat FSM is built only when PB_REPEAT_EN is defined; otherwise pb_repeat is tied low.
module pb_debounce_repeat #(
    parameter int          CNT_W        = 16,
    parameter logic [23:0] REPEAT_DELAY = 24'd12_500_000,
    parameter logic [23:0] REPEAT_RATE  = 24'd2_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic pb_n,
    output logic pb_state,
    output logic pb_down,
    output logic pb_up,
    output logic pb_repeat
);

    logic             s1;
    logic             s2;
    logic             pressed;
    logic [CNT_W-1:0] cnt;
    logic             cnt_full;

    // Synchroniser resets to "released" so a held button is seen as a fresh press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= pb_n;
            s2 <= s1;
        end
    end

    assign pressed  = ~s2;
    assign cnt_full = &cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            pb_state <= 1'b0;
            pb_down  <= 1'b0;
            pb_up    <= 1'b0;
        end else begin
            // NOTE: default-low pulse assignments first; the accept branch overrides them for one cycle only.
            pb_down <= 1'b0;
            pb_up   <= 1'b0;
            if (pressed == pb_state) begin
                cnt <= '0;
            end else if (!cnt_full) begin
                cnt <= cnt + 1'b1;
            end else begin
                pb_state <= pressed;
                cnt      <= '0;
                pb_down  <= pressed;
                pb_up    <= ~pressed;
            end
        end
    end

`ifdef PB_REPEAT_EN
    typedef enum logic [1:0] {
        RELEASED,
        HOLD,
        REPEAT
    } rstate_t;

    rstate_t     state;
    rstate_t     state_nxt;
    logic [23:0] rcnt;
    logic [23:0] rcnt_nxt;
    logic        repeat_nxt;
    logic        press_edge;
    logic        release_edge;

    // Same condition that raises pb_down / pb_up on this edge.
    assign press_edge   = cnt_full && (pressed != pb_state) && pressed;
    assign release_edge = cnt_full && (pressed != pb_state) && !pressed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RELEASED;
            rcnt      <= '0;
            pb_repeat <= 1'b0;
        end else begin
            state     <= state_nxt;
            rcnt      <= rcnt_nxt;
            pb_repeat <= repeat_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        rcnt_nxt   = rcnt;
        repeat_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (press_edge) begin
                    state_nxt = HOLD;
                    rcnt_nxt  = '0;
                end
            end
            HOLD: begin
                // Release takes priority over a terminal count on the same edge.
                if (release_edge) begin
                    state_nxt = RELEASED;
                    rcnt_nxt  = '0;
                end else if (rcnt == REPEAT_DELAY - 24'd1) begin
                    state_nxt  = REPEAT;
                    rcnt_nxt   = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + 24'd1;
                end
            end
            REPEAT: begin
                if (release_edge) begin
                    state_nxt = RELEASED;
                    rcnt_nxt  = '0;
                end else if (rcnt == REPEAT_RATE - 24'd1) begin
                    rcnt_nxt   = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + 24'd1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                rcnt_nxt  = '0;
            end
        endcase
    end
`else
    // Repeat timing parameters are referenced only so both builds share one parameter list.
    assign pb_repeat = 1'b0 && (REPEAT_DELAY != 24'd0) && (REPEAT_RATE != 24'd0);
`endif

endmodule

// File: tb/tb_pb_debounce_repeat.sv
// Self-checking bench for pb_debounce_repeat (CNT_W=4, REPEAT_DELAY=8, REPEAT_RATE=4) with a cycle-level reference model.
// Expectations for pb_repeat follow PB_REPEAT_EN the same way the design does.
module tb_pb_debounce_repeat;

    localparam int CNT_W  = 4;
    localparam int DELAY  = 8;
    localparam int RATE   = 4;
    localparam int SETTLE = 1 << CNT_W;
`ifdef PB_REPEAT_EN
    localparam int EXP_REP_HOLD = 6;
`else
    localparam int EXP_REP_HOLD = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic pb_n;
    logic pb_state;
    logic pb_down;
    logic pb_up;
    logic pb_repeat;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: input delay line, mismatch run length, and time since accepted press.
    logic q[$];
    logic m_state;
    logic m_down;
    logic m_up;
    logic m_rep;
    logic m_held;
    int   m_run;
    int   t;
    int   t_down;

    int n_down;
    int n_up;
    int n_rep;
    int last_down_t;
    int last_up_t;
    int t0;

    always #5 clock = ~clock;

    pb_debounce_repeat #(
        .CNT_W       (CNT_W),
        .REPEAT_DELAY(24'd8),
        .REPEAT_RATE (24'd4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pb_n     (pb_n),
        .pb_state (pb_state),
        .pb_down  (pb_down),
        .pb_up    (pb_up),
        .pb_repeat(pb_repeat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        q       = '{1'b1, 1'b1};
        m_state = 1'b0;
        m_down  = 1'b0;
        m_up    = 1'b0;
        m_rep   = 1'b0;
        m_held  = 1'b0;
        m_run   = 0;
        t       = 0;
        t_down  = 0;
    endtask

    task automatic clear_counts();
        n_down      = 0;
        n_up        = 0;
        n_rep       = 0;
        last_down_t = -1;
        last_up_t   = -1;
    endtask

    task automatic model_edge();
        logic p;
        t++;
        p = ~q[0];
        void'(q.pop_front());
        q.push_back(pb_n);
        m_down = 1'b0;
        m_up   = 1'b0;
        if (p != m_state) begin
            m_run++;
            if (m_run == SETTLE) begin
                m_state = p;
                m_run   = 0;
                if (p) m_down = 1'b1;
                else   m_up   = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        if (m_down) begin
            m_held = 1'b1;
            t_down = t;
        end
        if (m_up) m_held = 1'b0;
        m_rep = 1'b0;
`ifdef PB_REPEAT_EN
        if (m_held && (t - t_down) >= DELAY && ((t - t_down - DELAY) % RATE) == 0)
            m_rep = 1'b1;
`endif
    endtask

    task automatic check_outputs();
        check("pb_state", pb_state, m_state);
        check("pb_down", pb_down, m_down);
        check("pb_up", pb_up, m_up);
        check("pb_repeat", pb_repeat, m_rep);
        if (pb_down === 1'b1) begin n_down++; last_down_t = t; end
        if (pb_up === 1'b1) begin n_up++; last_up_t = t; end
        if (pb_repeat === 1'b1) n_rep++;
    endtask

    task automatic tick(input logic v);
        pb_n = v;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    initial begin
        reset = 1'b1;
        pb_n  = 1'b1;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clock);
        #3;
        check("reset_state", pb_state, 0);
        check("reset_down", pb_down, 0);
        check("reset_up", pb_up, 0);
        check("reset_repeat", pb_repeat, 0);
        reset = 1'b0;
        model_reset();

        // Clean press, held so the release edge lands on a terminal repeat count (down+32).
        clear_counts();
        run(1'b0, 32);
        check("press_edge", last_down_t, 18);
        run(1'b1, 25);
        check("release_edge", last_up_t, 50);
        check("hold_downs", n_down, 1);
        check("hold_ups", n_up, 1);
        check("hold_repeats", n_rep, EXP_REP_HOLD);

        // Bounce: low 10, high 1, low 20.
        clear_counts();
        t0 = t;
        run(1'b0, 10);
        run(1'b1, 1);
        run(1'b0, 20);
        check("bounce_downs", n_down, 1);
        check("bounce_edge", last_down_t, t0 + 29);
        run(1'b1, 25);
        check("bounce_ups", n_up, 1);

        // Glitches of 1 and 15 cycles must not be accepted.
        clear_counts();
        run(1'b0, 1);
        run(1'b1, 20);
        run(1'b0, 15);
        run(1'b1, 25);
        check("glitch_downs", n_down, 0);
        check("glitch_ups", n_up, 0);

        // Random bouncy activity against the model.
        for (int seg = 0; seg < 60; seg++) begin
            logic lvl;
            int   len;
            lvl = 1'(seg % 2 == 0);
            len = $urandom_range(1, 40);
            lvl = ~lvl;
            run(lvl, len);
        end
        run(1'b1, 25);

        // Asynchronous reset mid-hold with the button still pressed.
        run(1'b0, 30);
        check("prereset_state", pb_state, 1);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_state", pb_state, 0);
        check("midreset_down", pb_down, 0);
        check("midreset_up", pb_up, 0);
        check("midreset_repeat", pb_repeat, 0);
        #2;
        reset = 1'b0;
        model_reset();
        clear_counts();
        run(1'b0, 20);
        check("repress_downs", n_down, 1);
        check("repress_edge", last_down_t, 18);
        run(1'b1, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pb_debounce_repeat.md
# pb_debounce_repeat

Button front-end for the snake game's input path. Synchronises a raw, bouncy, active-low pushbutton, debounces it with a saturating stability counter, and emits a level plus one-cycle press, release and optional auto-repeat pulses. Sits directly upstream of the 10-bit counters; their enable inputs take `pb_up` (or `pb_repeat`) as a clean single-cycle step.

## Interface
- `CNT_W`, 16: debounce counter width. The input must differ from `pb_state` for 2^CNT_W consecutive cycles to be accepted.
- `REPEAT_DELAY`, 24'd12_500_000: cycles from `pb_down` to the first `pb_repeat`. Must be ≥1.
- `REPEAT_RATE`, 24'd2_500_000: cycles between later `pb_repeat` pulses. Must be ≥1.
- `clock` input 1: single system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pb_n` input 1: raw button, 0 = pressed; asynchronous to `clock`.
- `pb_state` output 1: debounced level, 1 = pressed.
- `pb_down` output 1: one-cycle pulse on the accepted press.
- `pb_up` output 1: one-cycle pulse on the accepted release.
- `pb_repeat` output 1: one-cycle auto-repeat pulse while held.

## Operation
- **Synchroniser:** two flops `s1`/`s2`, reset to 1 (released). `pressed = ~s2`.
- **Debounce counter** `cnt[CNT_W-1:0]`, reset 0, evaluated each edge:
  - If `pressed == pb_state`: `cnt` ← 0. Any one-cycle agreement restarts the count.
  - Else if `cnt != all-ones`: `cnt` ← `cnt+1`.
  - Else (`cnt == all-ones` and still mismatched): `pb_state` ← `pressed`, `cnt` ← 0, and the matching pulse register (`pb_down` if pressed, `pb_up` if released) ← 1.
- Pulse registers are 0 on every edge not listed above, so each is exactly one cycle wide.
- `pb_down` and `pb_up` are never high together. A second toggle needs another 2^CNT_W cycles.
- **Repeat FSM** (macro enabled only), states `RELEASED`, `HOLD`, `REPEAT`; 24-bit `rcnt`:
  - `RELEASED` → `HOLD` on the edge that raises `pb_down`; `rcnt` ← 0.
  - `HOLD`: `rcnt++` each edge. When `rcnt == REPEAT_DELAY-1`: `pb_repeat` ← 1, → `REPEAT`, `rcnt` ← 0.
  - `REPEAT`: `rcnt++` each edge. When `rcnt == REPEAT_RATE-1`: `pb_repeat` ← 1, `rcnt` ← 0.
  - `HOLD`/`REPEAT` → `RELEASED` on the edge that raises `pb_up`; `rcnt` ← 0. Release wins: no `pb_repeat` on that edge, even if `rcnt` hit its terminal value.
- **Reset**, asynchronous and at any time including mid-count or mid-hold:
  - `s1`=`s2`=1; `cnt`=0; `pb_state`=0; `pb_down`=`pb_up`=`pb_repeat`=0; FSM=`RELEASED`; `rcnt`=0.
  - A button held through reset release is re-accepted as a new press after full debounce latency.

## Timing
- Count edges from edge 1, the first rising edge that samples the new `pb_n` value.
  - `s2` reflects the new value after edge 2.
  - `pb_state` and the pulse change after edge 2^CNT_W + 2.
  - CNT_W=4 gives 18 edges.
- Bounce lasting k cycles adds at most k cycles; each agreeing cycle restarts the count.
- `pb_repeat` first rises exactly REPEAT_DELAY cycles after `pb_down` rises, then every REPEAT_RATE cycles.
- All outputs are registered; there is no combinational path from `pb_n` to any output.

## Configuration
- Macro: `PB_REPEAT_EN`.
- Defined: repeat FSM and `rcnt` are built; `pb_repeat` behaves as specified.
- Undefined: no FSM or `rcnt` logic; `pb_repeat` is tied to 0; `REPEAT_DELAY`/`REPEAT_RATE` are unused. Debounce behaviour is identical in both builds.

## Test plan
All scenarios use CNT_W=4, REPEAT_DELAY=8, REPEAT_RATE=4, `PB_REPEAT_EN` defined unless stated.
- **Reset values:** assert `reset` mid-cycle with `pb_n`=0 → all outputs 0 immediately. Deassert and hold `pb_n`=0 → `pb_down` one cycle after edge 18 following deassert.
- **Clean press/release:** `pb_n` 1→0 → `pb_state`/`pb_down` after edge 18, `pb_down` high one cycle only. `pb_n` 0→1 later → `pb_up` after edge 18, `pb_state`=0.
- **Bounce rejection:** `pb_n` low 10 cycles, high 1, low 20 → exactly one `pb_down`, after the 18th edge of the final low run.
- **Glitch rejection:** single-cycle and 15-cycle low pulses on `pb_n` → `pb_state` stays 0; no pulses.
- **Auto-repeat:** hold pressed 30 cycles past `pb_down` → `pb_repeat` at +8, +12, +16, +20, +24, +28. Then release → `pb_up`, no further `pb_repeat`, including when the release edge coincides with a terminal `rcnt`.
- **Macro off:** rebuild without `PB_REPEAT_EN`; repeat the auto-repeat stimulus → `pb_repeat` constantly 0; `pb_down`/`pb_up` timing unchanged.
